// File: rtl/iopin_pkg.sv
// ----------------------------------------------------------------------------
// iopin_pkg
//   Shared constants and helpers for the iopin_bank GPIO pad bank.
//   - SYNC_MIN  : shortest input synchroniser the bank accepts.
//   - MAX_WIDTH : largest number of pads one bank may carry.
//   - clog2()   : counter-width helper that never returns a zero width.
// ----------------------------------------------------------------------------
package iopin_pkg;

  localparam int SYNC_MIN  = 2;
  localparam int MAX_WIDTH = 32;

  // Width of a counter that must hold values 0..value-1 (minimum 1 bit).
  function automatic int clog2(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/iopin_sync.sv
// ----------------------------------------------------------------------------
// iopin_sync
//   One channel of the pad input path: a SYNC_STAGES-deep synchroniser, the
//   previous synchronised value, and combinational rise/fall detection.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     pad       : raw (asynchronous) pad value
//     in_data   : synchronised pad value (last synchroniser stage)
//     rise/fall : in_data changed 0->1 / 1->0 relative to the previous cycle
// ----------------------------------------------------------------------------
module iopin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic in_data,
  output logic rise,
  output logic fall
);

  // Stage 0 samples the pad; stage SYNC_STAGES-1 is the settled value.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: flops use non-blocking assignments so every stage samples the
  // value its neighbour held before the edge; blocking here would collapse
  // the chain into a single flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign in_data = sync_q[SYNC_STAGES-1];
  assign rise    = in_data & ~prev_q;
  assign fall    = ~in_data & prev_q;

endmodule

// File: rtl/iopin_bank.sv
// ----------------------------------------------------------------------------
// iopin_bank
//   Bank of WIDTH bidirectional GPIO pads between the SoC GPIO register block
//   and the board pins. Registered output data / output enable, hardened
//   input path with per-bit edge detection, sticky W1C edge status and one
//   aggregated interrupt line.
//   Ports:
//     clk, rst              : clock, asynchronous active-high reset
//     out_wr/out_wdata/out_mask : masked write of the output data register
//     oe_wr/oe_wdata        : full-width write of the output-enable register
//     rise_en/fall_en       : per-bit edge interrupt enables
//     irq_clr               : per-bit write-1-to-clear of irq_status
//     out_q, oe_q           : current output data / output enable
//     in_data               : synchronised pad values
//     irq_status, irq       : sticky edge flags and their OR
//     io                    : pads (tristate buffers map onto IOBUF)
// ----------------------------------------------------------------------------
module iopin_bank
  import iopin_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_OE    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             out_wr,
  input  logic [WIDTH-1:0] out_wdata,
  input  logic [WIDTH-1:0] out_mask,
  input  logic             oe_wr,
  input  logic [WIDTH-1:0] oe_wdata,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] oe_q,
  output logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] irq_status,
  output logic             irq,
  inout  wire  [WIDTH-1:0] io
);

  if (SYNC_STAGES < SYNC_MIN) begin : g_bad_sync
    $error("iopin_bank: SYNC_STAGES must be at least %0d", SYNC_MIN);
  end
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("iopin_bank: WIDTH must be within 1..%0d", MAX_WIDTH);
  end

  // Edges are only trusted once the synchroniser and edge history have been
  // refilled from live pad values after reset.
  localparam int              ARM_CYCLES = SYNC_STAGES + 1;
  localparam int              ARM_W      = clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_LAST  = ARM_W'(ARM_CYCLES);

  logic [ARM_W-1:0] arm_cnt;
  logic             armed;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] status_set;

  // Output data and output enable registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= RESET_OUT;
      oe_q  <= RESET_OE;
    end else begin
      if (out_wr) out_q <= (out_q & ~out_mask) | (out_wdata & out_mask);
      if (oe_wr)  oe_q  <= oe_wdata;
    end
  end

  // Arm counter saturates at ARM_CYCLES; reaching it is the sticky armed state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + 1'b1;
  end

  assign armed = (arm_cnt == ARM_LAST);

  // Pads and per-channel input path.
  for (genvar n = 0; n < WIDTH; n++) begin : g_pad
    assign io[n] = oe_q[n] ? out_q[n] : 1'bz;

    iopin_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .pad     (io[n]),
      .in_data (in_data[n]),
      .rise    (rise[n]),
      .fall    (fall[n])
    );
  end

  assign status_set = armed ? ((rise & rise_en) | (fall & fall_en)) : '0;

  // Set is OR-ed in after the clear so a new edge survives a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_status <= '0;
    else     irq_status <= (irq_status & ~irq_clr) | status_set;
  end

  assign irq = |irq_status;

endmodule

// File: tb/tb_iopin_bank.sv
// ----------------------------------------------------------------------------
// tb_iopin_bank
//   Directed bench for iopin_bank (WIDTH=4, SYNC_STAGES=2). An external pad
//   driver stands in for a weak pull: it drives ext_val on every pad the bank
//   is not driving. A cycle-level model predicts all outputs; a negedge
//   process compares against it every cycle, and literal checks pin the
//   model at the key points of each scenario.
// ----------------------------------------------------------------------------
module tb_iopin_bank;

  localparam int W = 4;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         out_wr = 1'b0;
  logic [W-1:0] out_wdata = '0;
  logic [W-1:0] out_mask = '0;
  logic         oe_wr = 1'b0;
  logic [W-1:0] oe_wdata = '0;
  logic [W-1:0] rise_en = '0;
  logic [W-1:0] fall_en = '0;
  logic [W-1:0] irq_clr = '0;
  logic [W-1:0] out_q;
  logic [W-1:0] oe_q;
  logic [W-1:0] in_data;
  logic [W-1:0] irq_status;
  logic         irq;
  wire  [W-1:0] io;

  logic [W-1:0] ext_val = '1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  iopin_bank #(
    .WIDTH       (W),
    .SYNC_STAGES (S),
    .RESET_OUT   (4'h0),
    .RESET_OE    (4'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .out_wr     (out_wr),
    .out_wdata  (out_wdata),
    .out_mask   (out_mask),
    .oe_wr      (oe_wr),
    .oe_wdata   (oe_wdata),
    .rise_en    (rise_en),
    .fall_en    (fall_en),
    .irq_clr    (irq_clr),
    .out_q      (out_q),
    .oe_q       (oe_q),
    .in_data    (in_data),
    .irq_status (irq_status),
    .irq        (irq),
    .io         (io)
  );

  // ---------------------------------------------------------------- model
  logic [W-1:0] m_out, m_oe, m_in, m_prev, m_stat;
  int           m_edges;
  logic [W-1:0] m_pipe[$];

  // External driver yields wherever the model says the bank drives the pad.
  for (genvar i = 0; i < W; i++) begin : g_ext
    assign io[i] = m_oe[i] ? 1'bz : ext_val[i];
  end

  always @(posedge clk or posedge rst) begin
    logic [W-1:0] pad, rise_v, fall_v, set_v;
    if (rst) begin
      m_out   <= '0;
      m_oe    <= '0;
      m_in    <= '0;
      m_prev  <= '0;
      m_stat  <= '0;
      m_edges <= 0;
      m_pipe.delete();
      for (int k = 0; k < S - 1; k++) m_pipe.push_back('0);
    end else begin
      pad    = (m_oe & m_out) | (~m_oe & ext_val);
      rise_v = m_in & ~m_prev;
      fall_v = ~m_in & m_prev;
      // Edges count only once S+1 clock edges have passed since reset.
      set_v  = (m_edges > S) ? ((rise_v & rise_en) | (fall_v & fall_en)) : '0;
      m_stat <= (m_stat & ~irq_clr) | set_v;
      m_prev <= m_in;
      m_pipe.push_back(pad);
      m_in   <= m_pipe.pop_front();
      if (m_edges <= S) m_edges <= m_edges + 1;
      if (out_wr) m_out <= (m_out & ~out_mask) | (out_wdata & out_mask);
      if (oe_wr)  m_oe  <= oe_wdata;
    end
  end

  // ---------------------------------------------------------------- checks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc out_q",      32'(out_q),      32'(m_out));
      check("cyc oe_q",       32'(oe_q),       32'(m_oe));
      check("cyc in_data",    32'(in_data),    32'(m_in));
      check("cyc irq_status", 32'(irq_status), 32'(m_stat));
      check("cyc irq",        32'(irq),        32'(|m_stat));
    end
  end

  // Advance n rising edges, then settle 2 ns past the last one.
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    rise_en = 4'hF;
    fall_en = 4'hF;
    #1 rst = 1'b1;
    cmp_en = 1'b1;
    #1;
    check("rst out_q",      32'(out_q),      32'h0);
    check("rst oe_q",       32'(oe_q),       32'h0);
    check("rst irq_status", 32'(irq_status), 32'h0);
    check("rst irq",        32'(irq),        32'h0);
    check("rst pads pulled",32'(io),         32'hF);
    tick(2);
    rst = 1'b0;
    tick(6);
    check("arm suppression status", 32'(irq_status), 32'h0);
    check("post-reset in_data",     32'(in_data),    32'hF);
    rise_en = '0;
    fall_en = '0;

    // Masked write, then drive all pads.
    out_wr = 1'b1; out_wdata = 4'hF; out_mask = 4'h5;
    tick();
    out_wr = 1'b0;
    check("masked write out_q", 32'(out_q), 32'h5);
    oe_wr = 1'b1; oe_wdata = 4'hF;
    tick();
    oe_wr = 1'b0;
    check("pads after oe write", 32'(io), 32'h5);
    tick(2);
    check("in_data after sync", 32'(in_data), 32'h5);

    // Edge capture on an externally driven pad 0.
    ext_val = 4'hE;
    oe_wr = 1'b1; oe_wdata = 4'h0;
    tick();
    oe_wr = 1'b0;
    tick(5);
    rise_en = 4'h1;
    ext_val = 4'hF;
    tick(2);
    check("rise in_data[0]",     32'(in_data[0]), 32'h1);
    check("status before set",   32'(irq_status), 32'h0);
    tick();
    check("rise irq_status",     32'(irq_status), 32'h1);
    check("rise irq",            32'(irq),        32'h1);
    ext_val = 4'hE;
    tick(5);
    check("disabled fall keeps", 32'(irq_status), 32'h1);

    // Clear racing a new enabled rise on bit 0: set wins.
    ext_val = 4'hF;
    tick(2);
    irq_clr = 4'h1;
    tick();
    irq_clr = 4'h0;
    check("w1c race keeps", 32'(irq_status), 32'h1);
    irq_clr = 4'h1;
    tick();
    irq_clr = 4'h0;
    check("w1c clears",     32'(irq_status), 32'h0);
    check("w1c irq low",    32'(irq),        32'h0);

    // Loopback: the bank's own driven edge on bit 1.
    rise_en = 4'h0;
    ext_val = 4'hD;
    tick(5);
    fall_en = 4'h2;
    oe_wr = 1'b1; oe_wdata = 4'h2;
    tick();
    oe_wr = 1'b0;
    tick(4);
    out_wr = 1'b1; out_wdata = 4'h2; out_mask = 4'h2;
    tick();
    out_wr = 1'b0;
    tick(5);
    check("loopback rise ignored", 32'(irq_status), 32'h0);
    out_wr = 1'b1; out_wdata = 4'h0; out_mask = 4'h2;
    tick();
    out_wr = 1'b0;
    tick(2);
    check("loopback not yet",  32'(irq_status), 32'h0);
    tick();
    check("loopback fall set", 32'(irq_status), 32'h2);
    check("loopback irq",      32'(irq),        32'h1);

    // Fill every status bit with all pads driven, then reset mid-run.
    rise_en = 4'hF;
    fall_en = 4'hF;
    oe_wr = 1'b1; oe_wdata = 4'hF;
    tick();
    oe_wr = 1'b0;
    out_wr = 1'b1; out_wdata = 4'hF; out_mask = 4'hF;
    tick();
    out_wr = 1'b0;
    tick(4);
    out_wr = 1'b1; out_wdata = 4'h0; out_mask = 4'hF;
    tick();
    out_wr = 1'b0;
    tick(5);
    check("pre-reset status", 32'(irq_status), 32'hF);
    check("pre-reset oe_q",   32'(oe_q),       32'hF);
    rst = 1'b1;
    ext_val = 4'hA;
    #1;
    check("async rst out_q",      32'(out_q),      32'h0);
    check("async rst oe_q",       32'(oe_q),       32'h0);
    check("async rst irq_status", 32'(irq_status), 32'h0);
    check("async rst irq",        32'(irq),        32'h0);
    check("async rst in_data",    32'(in_data),    32'h0);
    check("async rst pads",       32'(io),         32'hA);
    tick(2);
    rst = 1'b0;
    tick(8);
    check("re-arm no status", 32'(irq_status), 32'h0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
